// File: rtl/tpu_pkg.sv
// Shared state encoding, register offsets and default sizing for the
// systolic array controller.
package tpu_pkg;

    localparam int N_DEF          = 2;
    localparam int DW_DEF         = 32;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam logic [31:0] OFF_CTRL   = 32'h000;
    localparam logic [31:0] OFF_LEN    = 32'h004;
    localparam logic [31:0] OFF_STATUS = 32'h008;
    localparam logic [31:0] OFF_WEIGHT = 32'h010;
    localparam logic [31:0] OFF_RESULT = 32'h100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tpu_pe.sv
// Weight-stationary processing element: registers the incoming data for the
// next column and the accumulated partial sum for the next row.
module tpu_pe
    import tpu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_w,
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_psum,
    output logic [DW-1:0] o_x,
    output logic [DW-1:0] o_psum
);

    logic [DW-1:0] r_x;
    logic [DW-1:0] r_psum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x    <= '0;
            r_psum <= '0;
        end else begin
            r_x    <= i_x;
            r_psum <= i_psum + i_x * i_w;
        end
    end

    assign o_x    = r_x;
    assign o_psum = r_psum;

endmodule

// File: rtl/tpu_array_ctrl.sv
// N x N weight-stationary systolic array with input/result FIFOs, an APB
// register map and a job sequencer.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | popping LEN vectors into the array
//   ST_DRAIN | all vectors fed, waiting for the last result
//   ST_DONE  | job complete, held until start or clear done
module tpu_array_ctrl
    import tpu_pkg::*;
#(
    parameter int          N          = N_DEF,
    parameter int          DW         = DW_DEF,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N*DW-1:0] i_in_data,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_paddr,
    input  logic            i_psel,
    input  logic            i_penable,
    input  logic            i_pwrite,
    input  logic [31:0]     i_pwdata,
    output logic [31:0]     o_prdata,
    output logic            o_pready,
    output logic            o_pslverr,
    output logic            o_busy,
    output logic            o_done
);

    localparam int          VW    = N * DW;
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          LAT   = 2 * N;
    localparam int          WIW   = $clog2(N * N);
    localparam int          CW    = $clog2(N);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    state_t         r_state;
    logic [15:0]    r_len;
    logic [15:0]    r_remain;
    logic [DW-1:0]  r_w [N*N];
    logic [VW-1:0]  r_in_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_in_wp, r_in_rp;
    logic [AW:0]    r_in_cnt;
    logic [VW-1:0]  r_res_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_res_wp, r_res_rp;
    logic [AW:0]    r_res_cnt;
    logic [LAT-1:0] r_vld;
    logic [AW:0]    r_inflight;

    logic           w_acc, w_wr, w_rd, w_busy;
    logic [31:0]    w_off;
    logic           w_is_ctrl, w_is_len, w_is_stat, w_is_wgt, w_is_res;
    logic [WIW-1:0] w_wgt_idx;
    logic [CW-1:0]  w_col;
    logic           w_start, w_clr;
    logic           w_room, w_in_push, w_in_pop, w_res_push, w_res_pop, w_res_nempty;
    logic [VW-1:0]  w_in_head;
    logic [DW-1:0]  w_res_col;
    logic [VW-1:0]  w_res_vec;

    assign w_acc     = i_psel && i_penable;
    assign w_wr      = w_acc && i_pwrite;
    assign w_rd      = w_acc && !i_pwrite;
    assign w_off     = i_paddr - BASE_ADDR;
    assign w_is_ctrl = (w_off == OFF_CTRL);
    assign w_is_len  = (w_off == OFF_LEN);
    assign w_is_stat = (w_off == OFF_STATUS);
    assign w_is_wgt  = (w_off >= OFF_WEIGHT) && (w_off < OFF_WEIGHT + 32'(4*N*N))
                       && (w_off[1:0] == 2'b00);
    assign w_is_res  = (w_off >= OFF_RESULT) && (w_off < OFF_RESULT + 32'(4*N))
                       && (w_off[1:0] == 2'b00);
    assign w_wgt_idx = WIW'((w_off - OFF_WEIGHT) >> 2);
    assign w_col     = CW'((w_off - OFF_RESULT) >> 2);
    assign w_start   = w_wr && w_is_ctrl && i_pwdata[0];
    assign w_clr     = w_wr && w_is_ctrl && i_pwdata[1];

    assign o_busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done    = (r_state == ST_DONE);
    assign o_pready  = 1'b1;
    assign w_busy    = o_busy;

    // Room is reserved for every vector still travelling through the array,
    // so a push can never find the result FIFO full.
    assign w_room       = ({1'b0, r_res_cnt} + {1'b0, r_inflight}) < {1'b0, DEPTH};
    assign o_in_ready   = (r_in_cnt != DEPTH);
    assign w_in_push    = i_in_valid && o_in_ready;
    assign w_in_pop     = (r_state == ST_RUN) && (r_in_cnt != '0) && w_room;
    assign w_in_head    = r_in_mem[r_in_rp];
    assign w_res_push   = r_vld[LAT-1];
    assign w_res_nempty = (r_res_cnt != '0);
    assign w_res_col    = r_res_mem[r_res_rp][w_col*DW +: DW];
    assign w_res_pop    = w_rd && w_is_res && (w_col == CW'(N-1)) && w_res_nempty;

    assign o_pslverr = !i_rst && ((w_wr && w_busy && (w_is_wgt || w_is_len))
                                  || (w_rd && w_is_res && !w_res_nempty));

    always_comb begin
        o_prdata = '0;
        if (w_rd && !i_rst) begin
            if (w_is_ctrl)                     o_prdata = {30'b0, o_done, o_busy};
            else if (w_is_len)                 o_prdata = {16'b0, r_len};
            else if (w_is_stat)                o_prdata = {16'(r_res_cnt), 16'(r_in_cnt)};
            else if (w_is_wgt)                 o_prdata = 32'(r_w[w_wgt_idx]);
            else if (w_is_res && w_res_nempty) o_prdata = 32'(w_res_col);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len <= '0;
            for (int i = 0; i < N*N; i++) r_w[i] <= '0;
        end else if (w_wr && !w_busy) begin
            if (w_is_len) r_len <= i_pwdata[15:0];
            if (w_is_wgt) r_w[w_wgt_idx] <= DW'(i_pwdata);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) begin
                    if (r_len == '0) r_state <= ST_DONE;
                    else begin
                        r_state  <= ST_RUN;
                        r_remain <= r_len;
                    end
                end
                ST_RUN: if (w_in_pop) begin
                    r_remain <= r_remain - 16'd1;
                    if (r_remain == 16'd1) r_state <= ST_DRAIN;
                end
                ST_DRAIN: if (w_res_push && r_inflight == (AW+1)'(1)) r_state <= ST_DONE;
                ST_DONE:  if (w_start || w_clr) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_wp    <= '0;
            r_in_rp    <= '0;
            r_in_cnt   <= '0;
            r_res_wp   <= '0;
            r_res_rp   <= '0;
            r_res_cnt  <= '0;
            r_vld      <= '0;
            r_inflight <= '0;
        end else begin
            if (w_in_push) r_in_wp <= r_in_wp + 1'b1;
            if (w_in_pop)  r_in_rp <= r_in_rp + 1'b1;
            if (w_in_push != w_in_pop)
                r_in_cnt <= w_in_push ? r_in_cnt + 1'b1 : r_in_cnt - 1'b1;
            if (w_res_push) r_res_wp <= r_res_wp + 1'b1;
            if (w_res_pop)  r_res_rp <= r_res_rp + 1'b1;
            if (w_res_push != w_res_pop)
                r_res_cnt <= w_res_push ? r_res_cnt + 1'b1 : r_res_cnt - 1'b1;
            r_vld <= {r_vld[LAT-2:0], w_in_pop};
            if (w_in_pop != w_res_push)
                r_inflight <= w_in_pop ? r_inflight + 1'b1 : r_inflight - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_in_push)  r_in_mem[r_in_wp]   <= i_in_data;
        if (w_res_push) r_res_mem[r_res_wp] <= w_res_vec;
    end

    logic [DW-1:0] w_x       [N][N];
    logic [DW-1:0] w_psum    [N+1][N];
    logic [DW-1:0] w_col_out [N];

    // Row r is delayed r extra cycles so each vector moves as a diagonal wavefront.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [DW-1:0] r_dly [r+1];
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int k = 0; k <= r; k++) r_dly[k] <= '0;
            end else begin
                r_dly[0] <= w_in_pop ? w_in_head[r*DW +: DW] : '0;
                for (int k = 1; k <= r; k++) r_dly[k] <= r_dly[k-1];
            end
        end
        assign w_x[r][0] = r_dly[r];

        for (genvar c = 0; c < N; c++) begin : g_col
            if (c < N-1) begin : g_pass
                tpu_pe #(.DW(DW)) u_pe (
                    .i_clk  (i_clk),
                    .i_rst  (i_rst),
                    .i_w    (r_w[r*N+c]),
                    .i_x    (w_x[r][c]),
                    .i_psum (w_psum[r][c]),
                    .o_x    (w_x[r][c+1]),
                    .o_psum (w_psum[r+1][c])
                );
            end else begin : g_last
                logic [DW-1:0] w_x_unused;
                tpu_pe #(.DW(DW)) u_pe (
                    .i_clk  (i_clk),
                    .i_rst  (i_rst),
                    .i_w    (r_w[r*N+c]),
                    .i_x    (w_x[r][c]),
                    .i_psum (w_psum[r][c]),
                    .o_x    (w_x_unused),
                    .o_psum (w_psum[r+1][c])
                );
            end
        end
    end

    // Column c leaves the array N-1-c cycles before the last column.
    for (genvar c = 0; c < N; c++) begin : g_dsk
        if (c == N-1) begin : g_direct
            assign w_col_out[c] = w_psum[N][c];
        end else begin : g_delay
            logic [DW-1:0] r_dsk [N-1-c];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < N-1-c; k++) r_dsk[k] <= '0;
                end else begin
                    r_dsk[0] <= w_psum[N][c];
                    for (int k = 1; k < N-1-c; k++) r_dsk[k] <= r_dsk[k-1];
                end
            end
            assign w_col_out[c] = r_dsk[N-2-c];
        end
        assign w_psum[0][c]          = '0;
        assign w_res_vec[c*DW +: DW] = w_col_out[c];
    end

endmodule

// File: doc/tpu_array_ctrl.md
TPU_ARRAY_CTRL -- requirements
Module: tpu_array_ctrl

Interface
REQ-001 SHALL have parameter N, default 2: systolic array dimension (N x N PEs), legal range 2..8.
REQ-002 SHALL have parameter DW, default 32: data, weight and accumulator width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entries in each of the input and result FIFOs (power of two).
REQ-004 SHALL have parameter BASE_ADDR, default 0: APB base address of the register map.
REQ-005 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous and active-high.
REQ-007 i_in_data  input  N*DW  input vector x; element r occupies bits [r*DW +: DW].
REQ-008 i_in_valid  input  1  input vector valid; pushed into the input FIFO when i_in_valid && o_in_ready.
REQ-009 o_in_ready  output  1  input FIFO not full.
REQ-010 i_paddr, i_psel, i_penable, i_pwrite, i_pwdata  input  32/1/1/1/32  APB slave request.
REQ-011 o_prdata  output  32  APB read data; 0 when no read access is in progress.
REQ-012 o_pready / o_pslverr  output  1/1  pready is constant 1 (zero wait states); pslverr follows REQ-024 and REQ-025.
REQ-013 o_busy / o_done  output  1/1  job running / job complete (sticky).

Function
REQ-014 SHALL compute y[c] = sum over r of x[r]*W[r][c] for every accepted vector; unsigned; products and sums wrap modulo 2^DW.
REQ-015 Register map (byte offsets from BASE_ADDR):
- 0x00 CTRL: write bit0 = start, bit1 = clear done; read bit0 = busy, bit1 = done.
- 0x04 LEN: vectors per job, 16 bits.
- 0x08 STATUS: [15:0] input FIFO count, [31:16] result FIFO count.
- 0x10 + 4*(r*N+c): weight W[r][c].
- 0x100 + 4*c: result column c of the head result entry.
REQ-016 An APB access completes in the cycle with psel && penable; writes take effect at that clock edge.
REQ-017 FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN once LEN vectors have been popped.
- DRAIN -> DONE once the last result is pushed.
- DONE -> IDLE on clear done or on start.
REQ-018 Start with LEN=0 SHALL go IDLE -> DONE in one cycle with no FIFO activity.
REQ-019 Start while busy SHALL be ignored.
REQ-020 In RUN, one vector SHALL be popped per cycle only when the input FIFO is non-empty and (result count + in-flight vectors) < FIFO_DEPTH. Otherwise the feed stalls without losing data.
REQ-021 Feeding SHALL be skewed: row r enters the array r cycles after row 0.
- Fixed latency: a vector popped in cycle t has its full N*DW result pushed into the result FIFO at the edge ending cycle t+2N.
- Results are pushed in pop order.
REQ-022 Reading result column N-1 SHALL pop the result FIFO; reading columns 0..N-2 SHALL not pop.
REQ-023 A simultaneous result push and APB pop in the same cycle SHALL both occur, with the count unchanged.
REQ-024 A weight or LEN write while busy SHALL be ignored and return pslverr=1.
REQ-025 A result read while the result FIFO is empty SHALL return 0 with pslverr=1 and no pop.
REQ-026 Unmapped addresses SHALL read 0; writes to them are ignored; pslverr=0.
REQ-027 o_done SHALL be 1 in DONE only; o_busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-028 While i_rst=1, all state SHALL clear immediately, including during a job:
- FSM in IDLE; FIFOs empty; weights, LEN and PE accumulators 0.
- o_in_ready=1; o_busy=0; o_done=0; o_prdata=0; o_pslverr=0; o_pready=1.
REQ-029 The first push or APB access SHALL be accepted in the first cycle after i_rst deasserts.

Structure
REQ-030 Package tpu_pkg SHALL hold the FSM state enum, the register offset constants and the default values of N, DW and FIFO_DEPTH.
REQ-031 One sub-module, tpu_pe, SHALL implement a single registered multiply-accumulate PE (data pass-through plus partial-sum output), instantiated N*N times.
REQ-032 The FIFOs SHALL be internal to the block; there SHALL be no other sub-modules.

Verification
REQ-033 With N=2, W=[[1,2],[3,4]], LEN=1 and x=[5,6]: the result reads 23, 34, and o_done rises at t+4 (t = pop cycle, REQ-021) + 1.
REQ-034 With LEN=20 and 20 vectors streamed while APB is not reading: the feed stalls when the result count reaches 16; after draining, all 20 results are correct and in order.
REQ-035 With x=[0xFFFFFFFF,2] and W all 2: y=[2,2] (modulo 2^32).
REQ-036 Weight write while busy -> pslverr=1 and weight unchanged; result read while empty -> 0 with pslverr=1.
REQ-037 i_rst asserted mid-RUN -> all outputs at reset values in the same cycle; a new job afterwards with weights reloaded gives correct results.
REQ-038 LEN=0 start -> o_done=1 next cycle; STATUS reads 0.
